// File: rtl/hs32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// hs32_mem_arbiter
//
// Responder side of the HS32 core memory-request interface. Two initiators
// (channel 0 = instruction fetch, channel 1 = register file / execute) are
// granted round-robin. Each granted request is run as one read or write on a
// strobe/acknowledge memory bus and finished with a one-cycle ackm pulse to
// the initiator. If the memory does not answer within TIMEOUT cycles, the
// transaction is closed with err set (and ERR_DATA returned for reads).
//
// Parameters
//   TIMEOUT   max strobe cycles waited for mem_ack (0 = wait forever)
//   ERR_DATA  read data returned on a timed-out read
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   addr0/1, rw0/1, dtw0/1, reqm0/1   per-channel request (rw: 1 = write)
//   dtr0/1, ackm0/1, err0/1           per-channel response (registered)
//   mem_addr, mem_dout, mem_we, mem_stb   memory bus request
//   mem_din, mem_ack                      memory bus response
// ---------------------------------------------------------------------------
module hs32_mem_arbiter #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic        rw0,
   input  logic        rw1,
   input  logic [31:0] dtw0,
   input  logic [31:0] dtw1,
   input  logic        reqm0,
   input  logic        reqm1,
   output logic [31:0] dtr0,
   output logic [31:0] dtr1,
   output logic        ackm0,
   output logic        ackm1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_dout,
   output logic        mem_we,
   output logic        mem_stb,
   input  logic [31:0] mem_din,
   input  logic        mem_ack
);

   // Counter only has to reach TIMEOUT-1.
   localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic          last_reg;       // last granted channel
   logic          ch_reg;         // channel owning the current transaction
   logic [CW-1:0] cnt_reg;        // strobe cycles already waited
   logic [31:0]   mem_addr_reg;
   logic [31:0]   mem_dout_reg;
   logic          mem_we_reg;
   logic          mem_stb_reg;

   logic          grant_valid;
   logic          grant_ch;
   logic          bus_ack;
   logic          bus_tmo;
   logic          bus_end;

   logic [1:0]    ackm_vec;
   logic [1:0]    err_vec;
   logic [31:0]   dtr_vec [2];

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next state and per-cycle decisions
   // ------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      grant_valid = 1'b0;
      grant_ch    = 1'b0;
      bus_ack     = 1'b0;
      bus_tmo     = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (reqm0 || reqm1) begin
               grant_valid = 1'b1;
               // On a tie the channel that did not go last wins.
               grant_ch    = (reqm0 && reqm1) ? ~last_reg : reqm1;
               state_next  = S_BUS;
            end
         end
         S_BUS: begin
            // An ack in the limit cycle still counts as success.
            if (mem_ack) begin
               bus_ack    = 1'b1;
               state_next = S_RESP;
            end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
               bus_tmo    = 1'b1;
               state_next = S_RESP;
            end
         end
         S_RESP: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign bus_end = bus_ack | bus_tmo;

   // ------------------------------------------------------------------
   // Memory-bus side registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_reg     <= 1'b1;
         ch_reg       <= 1'b0;
         cnt_reg      <= '0;
         mem_addr_reg <= '0;
         mem_dout_reg <= '0;
         mem_we_reg   <= 1'b0;
         mem_stb_reg  <= 1'b0;
      end else begin
         if (grant_valid) begin
            mem_addr_reg <= grant_ch ? addr1 : addr0;
            mem_dout_reg <= grant_ch ? dtw1  : dtw0;
            mem_we_reg   <= grant_ch ? rw1   : rw0;
            mem_stb_reg  <= 1'b1;
            last_reg     <= grant_ch;
            ch_reg       <= grant_ch;
            cnt_reg      <= '0;
         end else if (bus_end) begin
            mem_stb_reg  <= 1'b0;
            mem_we_reg   <= 1'b0;
         end else if (state_reg == S_BUS) begin
            cnt_reg      <= cnt_reg + CW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-channel response registers. The response is registered on the
   // edge that leaves BUS, so ackm/err/dtr are all visible in RESP.
   // mem_we_reg still holds the transaction direction on that edge.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gen_ch
         logic        ackm_reg;
         logic        err_reg;
         logic [31:0] dtr_reg;
         logic        ch_done;

         assign ch_done = bus_end && (ch_reg == 1'(gi));

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               ackm_reg <= 1'b0;
               err_reg  <= 1'b0;
               dtr_reg  <= '0;
            end else begin
               ackm_reg <= ch_done;
               err_reg  <= ch_done && bus_tmo;
               if (ch_done && !mem_we_reg) begin
                  dtr_reg <= bus_ack ? mem_din : ERR_DATA;
               end
            end
         end

         assign ackm_vec[gi] = ackm_reg;
         assign err_vec[gi]  = err_reg;
         assign dtr_vec[gi]  = dtr_reg;
      end
   endgenerate

   assign ackm0    = ackm_vec[0];
   assign ackm1    = ackm_vec[1];
   assign err0     = err_vec[0];
   assign err1     = err_vec[1];
   assign dtr0     = dtr_vec[0];
   assign dtr1     = dtr_vec[1];
   assign mem_addr = mem_addr_reg;
   assign mem_dout = mem_dout_reg;
   assign mem_we   = mem_we_reg;
   assign mem_stb  = mem_stb_reg;

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for hs32_mem_arbiter (TIMEOUT = 4).
//
// The reference model works at transaction level: when a grant happens in
// cycle g with the memory choosing to ack after w wait cycles, the strobe
// window is g+1 .. g+L (L = w+1, or TIMEOUT if w >= TIMEOUT), and the
// response pulse lands in cycle g+L+1. Every cycle the DUT outputs are
// compared against that schedule. Directed scenarios come first, then a
// randomized phase with random requests, wait states and stray acks.
// ---------------------------------------------------------------------------
module tb_hs32_mem_arbiter;

   localparam int          T    = 4;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] addr0, addr1, dtw0, dtw1;
   logic        rw0, rw1, reqm0, reqm1;
   logic [31:0] dtr0, dtr1;
   logic        ackm0, ackm1, err0, err1;
   logic [31:0] mem_addr, mem_dout, mem_din;
   logic        mem_we, mem_stb, mem_ack;

   always #5 clk = ~clk;

   hs32_mem_arbiter #(.TIMEOUT(T), .ERR_DATA(ERRD)) dut (
      .clk(clk), .reset_n(reset_n),
      .addr0(addr0), .addr1(addr1), .rw0(rw0), .rw1(rw1),
      .dtw0(dtw0), .dtw1(dtw1), .reqm0(reqm0), .reqm1(reqm1),
      .dtr0(dtr0), .dtr1(dtr1), .ackm0(ackm0), .ackm1(ackm1),
      .err0(err0), .err1(err1),
      .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we),
      .mem_stb(mem_stb), .mem_din(mem_din), .mem_ack(mem_ack)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic        rw;
      logic [31:0] dtw;
   } txn_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   int          ntxn   = 0;

   // initiators
   txn_t        q0[$];
   txn_t        q1[$];
   logic        act [2];
   txn_t        cur [2];
   logic        ack_prev [2];
   logic        rand_mode;
   int          p_req;

   // memory behaviour
   int          force_w;
   int          spur_pct;
   logic [31:0] dq[$];

   // reference model
   logic [31:0] exp_dtr [2];
   logic        last_m;
   logic        g_valid;
   int          g, gw, gl;
   logic        g_ch, g_err;
   txn_t        g_txn;
   logic [31:0] g_data;
   int          next_free;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         act[i]      = 1'b0;
         ack_prev[i] = 1'b0;
         exp_dtr[i]  = '0;
         cur[i]      = '0;
      end
      last_m    = 1'b1;
      g_valid   = 1'b0;
      next_free = 0;
      q0.delete();
      q1.delete();
      dq.delete();
      reqm0     = 1'b0;
      reqm1     = 1'b0;
      mem_ack   = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".mem_stb"},  32'(mem_stb),  32'd0);
      chk({tag, ".mem_we"},   32'(mem_we),   32'd0);
      chk({tag, ".mem_addr"}, mem_addr,      32'd0);
      chk({tag, ".mem_dout"}, mem_dout,      32'd0);
      chk({tag, ".ackm0"},    32'(ackm0),    32'd0);
      chk({tag, ".ackm1"},    32'(ackm1),    32'd0);
      chk({tag, ".err0"},     32'(err0),     32'd0);
      chk({tag, ".err1"},     32'(err1),     32'd0);
      chk({tag, ".dtr0"},     dtr0,          32'd0);
      chk({tag, ".dtr1"},     dtr1,          32'd0);
   endtask

   function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
      txn_t t;
      t.addr = a;
      t.rw   = w;
      t.dtw  = d;
      return t;
   endfunction

   // One clock cycle: check outputs, then drive inputs for this cycle.
   task automatic step();
      logic in_win, ack_now, win2;
      txn_t t;
      @(posedge clk);
      #1;
      cyc++;

      in_win  = g_valid && (cyc >= g + 1) && (cyc <= g + gl);
      ack_now = g_valid && (cyc == g + gl + 1);
      if (ack_now && !g_txn.rw) exp_dtr[g_ch] = g_err ? ERRD : g_data;

      chk("mem_stb", 32'(mem_stb), 32'(in_win));
      chk("ackm0",   32'(ackm0),   32'(ack_now && !g_ch));
      chk("ackm1",   32'(ackm1),   32'(ack_now &&  g_ch));
      chk("err0",    32'(err0),    32'(ack_now && !g_ch && g_err));
      chk("err1",    32'(err1),    32'(ack_now &&  g_ch && g_err));
      chk("dtr0",    dtr0,         exp_dtr[0]);
      chk("dtr1",    dtr1,         exp_dtr[1]);
      if (in_win) begin
         chk("mem_addr", mem_addr,    g_txn.addr);
         chk("mem_we",   32'(mem_we), 32'(g_txn.rw));
         chk("mem_dout", mem_dout,    g_txn.dtw);
      end

      // initiators: drop reqm one cycle after seeing ackm, or roll on
      for (int i = 0; i < 2; i++) begin
         if (ack_prev[i]) begin
            act[i]      = 1'b0;
            ack_prev[i] = 1'b0;
         end
         if (!act[i]) begin
            if (i == 0 && q0.size() > 0) begin
               cur[0] = q0.pop_front();
               act[0] = 1'b1;
            end else if (i == 1 && q1.size() > 0) begin
               cur[1] = q1.pop_front();
               act[1] = 1'b1;
            end else if (rand_mode && int'($urandom_range(0, 99)) < p_req) begin
               t      = mk($urandom, 1'($urandom_range(0, 1)), $urandom);
               cur[i] = t;
               act[i] = 1'b1;
            end
         end
      end
      reqm0 = act[0]; addr0 = cur[0].addr; rw0 = cur[0].rw; dtw0 = cur[0].dtw;
      reqm1 = act[1]; addr1 = cur[1].addr; rw1 = cur[1].rw; dtw1 = cur[1].dtw;

      if (ack_now) begin
         ntxn++;
         $display("txn %0d: ch%0d %s addr=%08h err=%0d dtr0=%08h dtr1=%08h",
                  ntxn, g_ch, g_txn.rw ? "write" : "read ", g_txn.addr, g_err, dtr0, dtr1);
         ack_prev[g_ch] = 1'b1;
         g_valid        = 1'b0;
         next_free      = cyc + 1;
      end

      // grant decision for requests visible in this (idle) cycle
      if (!g_valid && cyc >= next_free && (act[0] || act[1])) begin
         g_ch    = (act[0] && act[1]) ? ~last_m : act[1];
         last_m  = g_ch;
         g       = cyc;
         g_txn   = cur[g_ch];
         gw      = (force_w >= 0) ? force_w : int'($urandom_range(0, 5));
         g_err   = (gw >= T);
         gl      = g_err ? T : gw + 1;
         g_data  = (dq.size() > 0) ? dq.pop_front() : $urandom;
         g_valid = 1'b1;
      end

      // memory responder; outside the strobe window acks are stray
      win2 = g_valid && (cyc >= g + 1) && (cyc <= g + gl);
      if (win2) begin
         mem_ack = !g_err && (cyc == g + 1 + gw);
         mem_din = mem_ack ? g_data : $urandom;
      end else begin
         mem_ack = (int'($urandom_range(0, 99)) < spur_pct);
         mem_din = $urandom;
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      reset_n   = 1'b1;
      addr0 = '0; addr1 = '0; dtw0 = '0; dtw1 = '0; rw0 = 1'b0; rw1 = 1'b0;
      mem_din   = '0;
      force_w   = -1;
      spur_pct  = 0;
      p_req     = 0;
      rand_mode = 1'b0;
      model_reset();

      // reset state
      #1 reset_n = 1'b0;
      #1 check_reset_outputs("reset");
      @(posedge clk);
      #1 check_reset_outputs("reset_hold");
      #3 reset_n = 1'b1;

      // single read, zero wait
      q0.push_back(mk(32'h0000_0100, 1'b0, 32'h0));
      dq.push_back(32'h1234_5678);
      force_w = 0;
      run(5);

      // write with 3 wait states on channel 1
      q1.push_back(mk(32'h0000_2000, 1'b1, 32'hCAFE_F00D));
      force_w = 3;
      run(8);

      // contention: both channels raised together, two transactions each
      q0.push_back(mk(32'h0000_00A0, 1'b0, 32'h0));
      q0.push_back(mk(32'h0000_00A4, 1'b0, 32'h0));
      q1.push_back(mk(32'h0000_00B0, 1'b1, 32'h5555_AAAA));
      q1.push_back(mk(32'h0000_00B4, 1'b0, 32'h0));
      force_w = 1;
      run(24);

      // timeout on a channel 0 read
      q0.push_back(mk(32'h0000_0300, 1'b0, 32'h0));
      force_w = 9;
      run(10);

      // back-to-back on channel 0 with stray acks around the bus window
      q0.push_back(mk(32'h0000_0400, 1'b0, 32'h0));
      q0.push_back(mk(32'h0000_0404, 1'b0, 32'h0));
      force_w  = 0;
      spur_pct = 100;
      run(10);
      spur_pct = 0;

      // reset in the middle of a stalled transaction
      q1.push_back(mk(32'h0000_0500, 1'b0, 32'h0));
      force_w = 9;
      for (int k = 0; k < 20 && !(g_valid && cyc >= g + 2); k++) step();
      if (!(g_valid && cyc >= g + 2)) begin
         checks++;
         errors++;
         $error("FAIL reset_mid_wait: observed=no strobe window expected=strobe within 20 cycles");
      end
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("reset_mid");
      model_reset();
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk("reset_mid.ackm0",   32'(ackm0),   32'd0);
         chk("reset_mid.ackm1",   32'(ackm1),   32'd0);
         chk("reset_mid.mem_stb", 32'(mem_stb), 32'd0);
      end
      #3 reset_n = 1'b1;
      q1.push_back(mk(32'h0000_0610, 1'b0, 32'h0));
      q0.push_back(mk(32'h0000_0600, 1'b0, 32'h0));
      force_w = 0;
      run(10);

      // randomized traffic
      rand_mode = 1'b1;
      p_req     = 35;
      force_w   = -1;
      spur_pct  = 20;
      run(1500);

      // drain
      rand_mode = 1'b0;
      spur_pct  = 0;
      for (int k = 0; k < 60 && (act[0] || act[1] || g_valid); k++) step();
      if (act[0] || act[1] || g_valid) begin
         checks++;
         errors++;
         $error("FAIL drain: observed=still busy expected=idle within 60 cycles");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
